// File: rtl/uart_rx_if.sv
// Serial line and received-byte strobes between the 8N1 receiver and user logic.
interface uart_rx_if;
  logic       uart_rx;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_frame_err;
  logic       uart_rx_busy;

  modport slave (
    input  uart_rx,
    output uart_rx_data, uart_rx_valid, uart_rx_frame_err, uart_rx_busy
  );

  modport master (
    output uart_rx,
    input  uart_rx_data, uart_rx_valid, uart_rx_frame_err, uart_rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 3-sample majority vote at mid-bit, one-cycle valid / frame-error pulses.
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronised line
//   START | timing the start bit; a high majority aborts as a glitch
//   DATA  | sampling eight data bits, LSB first
//   STOP  | sampling the stop bit; byte published or frame error flagged
module uart_rx #(
  parameter logic [12:0] BAUD_DIV     = 13'd87,
  parameter logic [12:0] BAUD_DIV_CAP = 13'd43
) (
  input  logic     clk_50m,
  input  logic     rst_n,
  uart_rx_if.slave rx_if
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [1:0]  smp_q, smp_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic [1:0]  vld_q, vld_d;
  logic        armed_q, armed_d;
  logic        sync1_q, rx_s_q, rx_s_d_q;

  logic maj, wrap, decide, fall;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      rx_s_d_q <= 1'b1;
    end else begin
      sync1_q  <= rx_if.uart_rx;
      rx_s_q   <= sync1_q;
      rx_s_d_q <= rx_s_q;
    end
  end

  // vld tracks when rx_s carries a real line sample rather than its reset value,
  // so a line held low through reset release cannot masquerade as a start edge.
  always_comb begin
    vld_d   = {vld_q[0], 1'b1};
    armed_d = armed_q | (vld_q[1] & rx_s_q);
  end

  assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
  assign wrap   = (cnt_q == BAUD_DIV);
  assign decide = (cnt_q == BAUD_DIV_CAP + 13'd1);
  assign fall   = armed_q & ~rx_s_q & rx_s_d_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = 13'd0;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    smp_d   = smp_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = wrap ? 13'd0 : cnt_q + 13'd1;
      if (cnt_q == BAUD_DIV_CAP - 13'd1) smp_d[0] = rx_s_q;
      if (cnt_q == BAUD_DIV_CAP)         smp_d[1] = rx_s_q;
    end

    case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        if (decide && maj) begin
          state_d = IDLE;
          cnt_d   = 13'd0;
        end else if (wrap) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (decide) shreg_d[idx_q] = maj;
        if (wrap) begin
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (decide) begin
          if (maj) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = IDLE;
          cnt_d   = 13'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 13'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      smp_q   <= 2'b11;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      smp_q   <= smp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      vld_q   <= vld_d;
      armed_q <= armed_d;
    end
  end

  assign rx_if.uart_rx_data      = data_q;
  assign rx_if.uart_rx_valid     = valid_q;
  assign rx_if.uart_rx_frame_err = ferr_q;
  assign rx_if.uart_rx_busy      = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous 8N1 UART receiver clocked by the 50 MHz system clock. It recovers frames from the serial line and presents each good byte with a one-cycle valid strobe; framing errors are flagged and the byte is discarded. It is the receive counterpart of the driver-library UART transmitter and uses the same bit period: `BAUD_DIV+1` clocks, 88 by default, about 568.2 kbaud at 50 MHz. It sits between the board RX pin and user logic.

## Interface
Parameters:
- `BAUD_DIV`, 13'd87: the bit period is `BAUD_DIV+1` clocks; the bit counter runs 0..`BAUD_DIV`, then wraps to 0.
- `BAUD_DIV_CAP`, 13'd43: mid-bit sample point. Constraint: 1 ≤ `BAUD_DIV_CAP` and `BAUD_DIV_CAP`+1 < `BAUD_DIV`.

Ports:
- `clk_50m`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `uart_rx`, input, 1: serial line, asynchronous to the clock. Idles high.
- `uart_rx_data`, output, 8: last good byte. Holds its value until the next good frame.
- `uart_rx_valid`, output, 1: one-cycle pulse when `uart_rx_data` updates.
- `uart_rx_frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `uart_rx_busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- **Input synchroniser.** Two flops with reset value 1; the output is `rx_s`. A third flop holds `rx_s_d` (reset 1) for edge detection.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `rx_s`=0 with `rx_s_d`=1 (falling edge) moves to START and clears the counter to 0. A line held low does not retrigger.
  - In every non-IDLE state the counter increments each clock and wraps `BAUD_DIV`→0.
  - Sampling: capture `rx_s` at counter = `CAP`-1, `CAP`, `CAP`+1. The bit value is the 2-of-3 majority, decided on the edge that ends the counter=`CAP`+1 cycle (the "decision edge").
  - START: majority 1 means a glitch: return to IDLE at the decision edge with no output activity. Majority 0 means stay in START until the wrap, then enter DATA with bit index 0.
  - DATA: at each decision edge, shift the majority into bit [index] of the shift register (LSB first). At each wrap, increment the index. The wrap after index 7 enters STOP.
  - STOP, at its decision edge:
    - Majority 1: load the shift register into `uart_rx_data` and pulse `uart_rx_valid`.
    - Majority 0: pulse `uart_rx_frame_err` and leave `uart_rx_data` unchanged.
    - Either way, go to IDLE on the same edge. The second half of the stop bit is not waited out, so a following start edge is caught.
- **Reset** (async, any time, including mid-frame):
  - FSM to IDLE; counter, index and shift register to 0.
  - `uart_rx_data`=0, `uart_rx_valid`=0, `uart_rx_frame_err`=0, `uart_rx_busy`=0.
  - Synchroniser and `rx_s_d` to 1.
  - A line already low at reset release does not start a frame until it has been seen high.
- `uart_rx_valid` and `uart_rx_frame_err` are never high in the same cycle.

## Timing
- Let edge k0 be the first clock edge whose first synchroniser flop samples `uart_rx` low.
  - k0+2: FSM enters START; `uart_rx_busy` rises.
  - Bit b (start=0, data 0..7 = b 1..8, stop=9) has its counter value j during the cycle after edge k0+2+88b+j.
  - Start-bit decision edge: k0+47.
  - Stop-bit decision edge: k0+839. `uart_rx_valid` (or `uart_rx_frame_err`) is high for the single cycle after k0+839, and `uart_rx_data` changes at that same edge. `uart_rx_busy` falls there too.
- General latency: 2 + 9·(`BAUD_DIV`+1) + `BAUD_DIV_CAP` + 2 clocks.
- Clock tolerance: the centre sample stays valid for a frame-average baud mismatch of up to about ±4.5% with the default parameters.
- Any single-clock spike within the 3-sample window is rejected by the majority vote.

## Test plan
- **Reset:** hold `rst_n`=0 with `uart_rx`=1, then release → all outputs 0. Idle for 2000 clocks → no pulses.
- **Good frame:** send 0xA5 (88-clock bits) → `uart_rx_valid` is high exactly one cycle, 839 clocks after k0; `uart_rx_data`=0xA5; `uart_rx_frame_err` stays 0. Repeat with a 1-clock inverted spike at counter=43 of data bit 2 → data is still 0xA5.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap → two valid pulses exactly 880 clocks apart; data reads 0x00 then 0xFF.
- **Glitch:** a 20-clock low pulse on an idle line → `uart_rx_busy` is high from k0+2 through k0+47 (falls at that edge); no valid or error pulse; `uart_rx_data` unchanged.
- **Framing error:** after 0xA5, send 0x3C with the stop bit low, then hold the line low for 2000 clocks → `uart_rx_frame_err` pulses once at k0+839; `uart_rx_data` stays 0xA5; no restart while the line is low. Then raise the line and send 0x11 → valid with 0x11.
- **Mid-frame reset:** assert `rst_n` during data bit 4 → outputs are 0 immediately. Release while the remainder of the frame plays out → no valid or error pulse is produced by that partial frame. Then send 0x5A → valid with 0x5A.
